// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, status bit positions and state encodings
// for the receiver and for the word loader that sits downstream of it.
package uart_pkg;

  // UART Lite register map
  localparam logic [3:0] UART_RXFIFO_ADDR = 4'h0;
  localparam logic [3:0] UART_TXFIFO_ADDR = 4'h4;
  localparam logic [3:0] UART_STAT_ADDR   = 4'h8;
  localparam logic [3:0] UART_CTRL_ADDR   = 4'hC;

  // Status register bit positions
  localparam int unsigned UART_STAT_RX_VALID = 0;
  localparam int unsigned UART_STAT_RX_FULL  = 1;
  localparam int unsigned UART_STAT_TX_EMPTY = 2;
  localparam int unsigned UART_STAT_TX_FULL  = 3;

  // AXI4-lite byte receiver states
  typedef enum logic [1:0] {
    RxIdle,
    RxAddr,
    RxData,
    RxResp
  } rx_state_e;

  // Word loader states, kept as plain constants so older flows can consume them
  typedef logic [2:0] ldr_state_t;
  localparam ldr_state_t LdrIdle     = 3'd0;
  localparam ldr_state_t LdrStatReq  = 3'd1;
  localparam ldr_state_t LdrStatWait = 3'd2;
  localparam ldr_state_t LdrDataReq  = 3'd3;
  localparam ldr_state_t LdrDataWait = 3'd4;
  localparam ldr_state_t LdrOut      = 3'd5;

endpackage

// File: rtl/uart_word_loader_if.sv
// Bundle between the word loader, the UART byte receiver and the word consumer.
//   rx_en/rx_addr     : request side driven by the loader
//   rx_data/rx_done   : completion side driven by the receiver
//   word_data/valid   : assembled word stream driven by the loader
//   word_ready        : backpressure from the program/data loader
// master = word loader, slave = receiver plus downstream consumer.
interface uart_word_loader_if;
  logic        rx_en;
  logic [3:0]  rx_addr;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output rx_en, rx_addr, word_data, word_valid,
    input  rx_data, rx_done, word_ready
  );

  modport slave (
    input  rx_en, rx_addr, word_data, word_valid,
    output rx_data, rx_done, word_ready
  );
endinterface

// File: rtl/uart_word_loader.sv
// Polls the UART status register until the RX FIFO holds data, reads one byte at a
// time and packs BYTES_PER_WORD bytes into a 32-bit word offered on a valid/ready stream.
//   clk, rst      : clock and synchronous active-high reset
//   enable        : level, keep loading words while high
//   bus           : receiver request/completion and output word stream (master side)
//   words_loaded  : count of words accepted downstream (wraps)
module uart_word_loader
  import uart_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter logic [3:0]  STAT_ADDR      = UART_STAT_ADDR,
  parameter logic [3:0]  RXFIFO_ADDR    = UART_RXFIFO_ADDR,
  parameter int unsigned RX_VALID_BIT   = UART_STAT_RX_VALID
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  uart_word_loader_if.master        bus,
  output logic               [31:0] words_loaded
);

  localparam logic [1:0] LastCnt = 2'(BYTES_PER_WORD - 1);

  ldr_state_t  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        rx_en_q, rx_en_d;
  logic [3:0]  rx_addr_q, rx_addr_d;
  logic [31:0] words_loaded_q, words_loaded_d;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    word_valid_d   = word_valid_q;
    rx_addr_d      = rx_addr_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      LdrIdle: begin
        if (enable) begin
          state_d   = LdrStatReq;
          rx_addr_d = STAT_ADDR;
        end
      end
      LdrStatReq: state_d = LdrStatWait;
      LdrStatWait: begin
        if (bus.rx_done) begin
          if (bus.rx_data[RX_VALID_BIT]) begin
            state_d   = LdrDataReq;
            rx_addr_d = RXFIFO_ADDR;
          end else if (enable) begin
            state_d = LdrStatReq;
          end else begin
            state_d = LdrIdle;
          end
        end
      end
      LdrDataReq: state_d = LdrDataWait;
      LdrDataWait: begin
        if (bus.rx_done) begin
          // First byte of a word starts from a clean register so no stale lanes survive.
          word_d = (byte_cnt_q == 2'd0) ? 32'h0 : word_q;
          for (int k = 0; k < 4; k++) begin
            if (byte_cnt_q == 2'(k)) begin
              if (BIG_ENDIAN) word_d[31-8*k -: 8] = bus.rx_data;
              else            word_d[8*k +: 8]    = bus.rx_data;
            end
          end
          rx_addr_d = STAT_ADDR;
          if (byte_cnt_q == LastCnt) begin
            byte_cnt_d   = 2'd0;
            word_valid_d = 1'b1;
            state_d      = LdrOut;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            // Partial word is retained while parked; assembly resumes at byte_cnt.
            state_d    = enable ? LdrStatReq : LdrIdle;
          end
        end
      end
      LdrOut: begin
        if (bus.word_ready) begin
          word_valid_d   = 1'b0;
          words_loaded_d = words_loaded_q + 32'd1;
          state_d        = enable ? LdrStatReq : LdrIdle;
        end
      end
      default: state_d = LdrIdle;
    endcase

    // Request pulse is high exactly for the cycle spent in a *_REQ state.
    rx_en_d = (state_d == LdrStatReq) || (state_d == LdrDataReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LdrIdle;
      byte_cnt_q     <= 2'd0;
      word_q         <= 32'h0;
      word_valid_q   <= 1'b0;
      rx_en_q        <= 1'b0;
      rx_addr_q      <= STAT_ADDR;
      words_loaded_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      word_valid_q   <= word_valid_d;
      rx_en_q        <= rx_en_d;
      rx_addr_q      <= rx_addr_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign bus.rx_en      = rx_en_q;
  assign bus.rx_addr    = rx_addr_q;
  assign bus.word_data  = word_q;
  assign bus.word_valid = word_valid_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_uart_word_loader.sv
module tb_uart_word_loader;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] words_be, words_le;

  uart_word_loader_if bus();
  uart_word_loader_if bus_le();

  always #5 clk = ~clk;

  uart_word_loader #(
    .BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1), .STAT_ADDR(4'h8), .RXFIFO_ADDR(4'h0), .RX_VALID_BIT(0)
  ) dut_be (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus), .words_loaded(words_be)
  );

  // Little-endian twin sees identical receiver traffic, so it runs in lockstep.
  uart_word_loader #(
    .BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0), .STAT_ADDR(4'h8), .RXFIFO_ADDR(4'h0), .RX_VALID_BIT(0)
  ) dut_le (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus_le), .words_loaded(words_le)
  );

  assign bus_le.rx_data    = bus.rx_data;
  assign bus_le.rx_done    = bus.rx_done;
  assign bus_le.word_ready = bus.word_ready;

  int checks = 0;
  int failures = 0;

  // Receiver model state and traffic log
  logic [7:0] stat_q[$];
  logic [7:0] data_q[$];
  logic [3:0] addr_log[$];
  int stat_reads, data_reads, rx_en_seen, violations, max_lat;
  bit         pending;
  int         lat_cnt;
  logic [7:0] resp;
  logic [3:0] req_addr;

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      bus.rx_done = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (bus.rx_en) rx_en_seen++;
        if (pending) begin
          if (bus.rx_en || bus.rx_addr !== req_addr) violations++;
          if (lat_cnt == 0) begin
            bus.rx_done = 1'b1;
            bus.rx_data = resp;
            pending = 1'b0;
          end else begin
            lat_cnt--;
          end
        end else if (bus.rx_en) begin
          pending  = 1'b1;
          req_addr = bus.rx_addr;
          lat_cnt  = $urandom_range(0, max_lat);
          addr_log.push_back(bus.rx_addr);
          if (bus.rx_addr == UART_STAT_ADDR) begin
            stat_reads++;
            resp = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h01;
          end else if (bus.rx_addr == UART_RXFIFO_ADDR) begin
            data_reads++;
            resp = (data_q.size() > 0) ? data_q.pop_front() : 8'h5A;
          end else begin
            violations++;
            resp = 8'h00;
          end
        end
      end
    end
  end

  // Reference packing: first received byte is most significant (BE) or least (LE).
  function automatic logic [31:0] pack_be(input logic [7:0] b0, b1, b2, b3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [31:0] pack_le(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    stat_q.delete();
    data_q.delete();
    addr_log.delete();
    stat_reads = 0;
    data_reads = 0;
    rx_en_seen = 0;
    violations = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    enable = 1'b0;
    bus.word_ready = 1'b0;
    max_lat = 2;
    tick(3);
    clear_model();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!bus.word_valid && n < budget) begin
      tick(1);
      n++;
    end
    ok = bus.word_valid;
  endtask

  task automatic wait_data_reads(input int target, input int budget, output bit ok);
    int n = 0;
    while (data_reads < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (data_reads >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    bus.word_ready = 1'b0;
    max_lat = 2;
    tick(3);
    checks++; if (bus.rx_en !== 1'b0) begin failures++; $display("FAIL reset_rx_en: got %b want 0", bus.rx_en); end
    checks++; if (bus.rx_addr !== 4'h8) begin failures++; $display("FAIL reset_rx_addr: got %h want 8", bus.rx_addr); end
    checks++; if (bus.word_data !== 32'h0) begin failures++; $display("FAIL reset_word_data: got %h want 0", bus.word_data); end
    checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
    checks++; if (words_be !== 32'h0) begin failures++; $display("FAIL reset_words_loaded: got %0d want 0", words_be); end
    checks++; if (bus_le.word_data !== 32'h0) begin failures++; $display("FAIL reset_le_word: got %h want 0", bus_le.word_data); end
    enable = 1'b0;
    clear_model();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_empty_fifo();
    bit ok;
    logic [7:0] b1, b2, b3;
    apply_reset();
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    stat_q = '{8'h00, 8'h00, 8'h00, 8'h01};
    data_q = '{8'hAB, b1, b2, b3};
    enable = 1'b1;
    wait_data_reads(1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_first_read: timeout, data_reads=%0d want 1", data_reads); end
    checks++; if (stat_reads != 4) begin failures++; $display("FAIL empty_stat_reads: got %0d want 4", stat_reads); end
    checks++; if (data_reads != 1) begin failures++; $display("FAIL empty_data_reads: got %0d want 1", data_reads); end
    checks++;
    if (addr_log.size() != 5) begin
      failures++; $display("FAIL empty_addr_log_len: got %0d want 5", addr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [3:0] want;
        want = (i < 4) ? 4'h8 : 4'h0;
        checks++;
        if (addr_log[i] !== want) begin
          failures++; $display("FAIL empty_addr_%0d: got %h want %h", i, addr_log[i], want);
        end
      end
    end
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL empty_word_valid: timeout got 0 want 1"); end
    checks++; if (bus.word_data !== pack_be(8'hAB, b1, b2, b3)) begin failures++; $display("FAIL empty_word_be: got %h want %h", bus.word_data, pack_be(8'hAB, b1, b2, b3)); end
    checks++; if (bus_le.word_data !== pack_le(8'hAB, b1, b2, b3)) begin failures++; $display("FAIL empty_word_le: got %h want %h", bus_le.word_data, pack_le(8'hAB, b1, b2, b3)); end
    enable = 1'b0;
    bus.word_ready = 1'b1;
    tick(1);
    bus.word_ready = 1'b0;
    checks++; if (words_be !== 32'd1) begin failures++; $display("FAIL empty_words_loaded: got %0d want 1", words_be); end
    checks++; if (violations != 0) begin failures++; $display("FAIL empty_protocol: got %0d violations want 0", violations); end
  endtask

  task automatic test_endianness();
    bit ok;
    apply_reset();
    data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    enable = 1'b1;
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL endian_valid: timeout got 0 want 1"); end
    checks++; if (bus.word_data !== 32'hDEADBEEF) begin failures++; $display("FAIL endian_be: got %h want deadbeef", bus.word_data); end
    checks++; if (bus_le.word_data !== 32'hEFBEADDE) begin failures++; $display("FAIL endian_le: got %h want efbeadde", bus_le.word_data); end
    checks++; if (words_be !== 32'd0) begin failures++; $display("FAIL endian_count_pre: got %0d want 0", words_be); end
    enable = 1'b0;
    bus.word_ready = 1'b1;
    tick(1);
    bus.word_ready = 1'b0;
    checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL endian_valid_drop: got %b want 0", bus.word_valid); end
    checks++; if (words_be !== 32'd1 || words_le !== 32'd1) begin failures++; $display("FAIL endian_count: got %0d/%0d want 1/1", words_be, words_le); end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [31:0] snap;
    int en_snap, stat_snap;
    logic [7:0] b[4];
    apply_reset();
    max_lat = 3;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      data_q.push_back(b[i]);
    end
    enable = 1'b1;
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_valid: timeout got 0 want 1"); end
    checks++; if (bus.word_data !== pack_be(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL bp_word: got %h want %h", bus.word_data, pack_be(b[0], b[1], b[2], b[3])); end
    snap = bus.word_data;
    en_snap = rx_en_seen;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.word_data !== snap || bus.word_valid !== 1'b1) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp_hold: got unstable word/valid want held %h", snap); end
    checks++; if (rx_en_seen != en_snap) begin failures++; $display("FAIL bp_no_rx_en: got %0d pulses want 0", rx_en_seen - en_snap); end
    stat_snap = stat_reads;
    bus.word_ready = 1'b1;
    tick(1);
    bus.word_ready = 1'b0;
    checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop: got %b want 0", bus.word_valid); end
    for (int i = 0; i < 5 && stat_reads == stat_snap; i++) tick(1);
    checks++; if (stat_reads != stat_snap + 1 || addr_log[$] !== 4'h8) begin failures++; $display("FAIL bp_poll_restart: got %0d new status reads want 1", stat_reads - stat_snap); end
    enable = 1'b0;
    tick(10);
  endtask

  task automatic test_enable_drop();
    bit ok;
    int en_snap;
    apply_reset();
    data_q = '{8'h11, 8'h22};
    enable = 1'b1;
    wait_data_reads(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_reads: timeout got %0d want 2", data_reads); end
    enable = 1'b0;
    tick(6);
    en_snap = rx_en_seen;
    tick(10);
    checks++; if (rx_en_seen != en_snap) begin failures++; $display("FAIL drop_parked: got %0d rx_en pulses want 0", rx_en_seen - en_snap); end
    checks++; if (stat_reads != 2 || data_reads != 2) begin failures++; $display("FAIL drop_counts: got %0d/%0d want 2/2", stat_reads, data_reads); end
    checks++; if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL drop_valid: got %b want 0", bus.word_valid); end
    data_q.push_back(8'h33);
    data_q.push_back(8'h44);
    enable = 1'b1;
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_resume_valid: timeout got 0 want 1"); end
    checks++; if (bus.word_data !== 32'h11223344) begin failures++; $display("FAIL drop_word_be: got %h want 11223344", bus.word_data); end
    checks++; if (bus_le.word_data !== 32'h44332211) begin failures++; $display("FAIL drop_word_le: got %h want 44332211", bus_le.word_data); end
    enable = 1'b0;
    bus.word_ready = 1'b1;
    tick(1);
    bus.word_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) data_q.push_back(8'($urandom));
    enable = 1'b1;
    wait_data_reads(4, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_reads: timeout got %0d want 4", data_reads); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (bus.rx_en !== 1'b0 || bus.rx_addr !== 4'h8 || bus.word_data !== 32'h0 ||
        bus.word_valid !== 1'b0 || words_be !== 32'h0) begin
      failures++;
      $display("FAIL rmid_outputs: got en=%b addr=%h data=%h valid=%b cnt=%0d want 0/8/0/0/0",
               bus.rx_en, bus.rx_addr, bus.word_data, bus.word_valid, words_be);
    end
    clear_model();
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    rst = 1'b0;
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_valid: timeout got 0 want 1"); end
    checks++; if (bus.word_data !== 32'h01020304) begin failures++; $display("FAIL rmid_word_be: got %h want 01020304", bus.word_data); end
    checks++; if (bus_le.word_data !== 32'h04030201) begin failures++; $display("FAIL rmid_word_le: got %h want 04030201", bus_le.word_data); end
    checks++; if (data_reads != 4) begin failures++; $display("FAIL rmid_data_reads: got %0d want 4", data_reads); end
    enable = 1'b0;
    bus.word_ready = 1'b1;
    tick(1);
    bus.word_ready = 1'b0;
    checks++; if (words_be !== 32'd1) begin failures++; $display("FAIL rmid_count: got %0d want 1", words_be); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp_stat;
    logic [7:0] b[4];
    apply_reset();
    max_lat = 3;
    exp_stat = 0;
    enable = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 4; i++) begin
        int nr;
        nr = $urandom_range(0, 2);
        for (int j = 0; j < nr; j++) stat_q.push_back(8'($urandom) & 8'hFE);
        stat_q.push_back(8'($urandom) | 8'h01);
        exp_stat += nr + 1;
        b[i] = 8'($urandom);
        data_q.push_back(b[i]);
      end
      wait_valid(600, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_valid_%0d: timeout got 0 want 1", w); end
      checks++; if (bus.word_data !== pack_be(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL b2b_be_%0d: got %h want %h", w, bus.word_data, pack_be(b[0], b[1], b[2], b[3])); end
      checks++; if (bus_le.word_data !== pack_le(b[0], b[1], b[2], b[3])) begin failures++; $display("FAIL b2b_le_%0d: got %h want %h", w, bus_le.word_data, pack_le(b[0], b[1], b[2], b[3])); end
      tick($urandom_range(0, 3));
      if (w == 5) enable = 1'b0;
      bus.word_ready = 1'b1;
      tick(1);
      bus.word_ready = 1'b0;
      checks++; if (words_be !== 32'(w + 1)) begin failures++; $display("FAIL b2b_count_%0d: got %0d want %0d", w, words_be, w + 1); end
    end
    tick(10);
    checks++; if (stat_reads != exp_stat || data_reads != 24) begin failures++; $display("FAIL b2b_reads: got %0d/%0d want %0d/24", stat_reads, data_reads, exp_stat); end
    checks++; if (violations != 0) begin failures++; $display("FAIL b2b_protocol: got %0d violations want 0", violations); end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    bus.word_ready = 1'b0;
    max_lat = 2;
    clear_model();
    test_reset();
    test_empty_fifo();
    test_endianness();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
